riscv_mc_cpu: RTL and testbench

RISCV_MC_CPU -- requirements
Module: riscv_mc_cpu

---
 rtl/riscv_mc_cpu.sv | 268 ++++++++++++++++++++++++++
 tb/tb_riscv_mc_cpu.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_cpu.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT with a single
// request/ready memory port and a bus-timeout watchdog on every access.
module riscv_mc_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Result,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] WAIT_LAST = MAX_WAIT - 1;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] wait_q, wait_d;
    logic        rf_we;

    logic [31:0] rf [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_lw, is_sw, is_opi, is_opr;
    logic        legal, taken, timeout;
    logic [31:0] op_b, alu_res, ls_addr;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_br    = (opcode == OP_BRANCH);
    assign is_lw    = (opcode == OP_LOAD);
    assign is_sw    = (opcode == OP_STORE);
    assign is_opi   = (opcode == OP_IMM);
    assign is_opr   = (opcode == OP_REG);

    always_comb begin
        legal = 1'b0;
        if (is_lui || is_auipc || is_jal)
            legal = 1'b1;
        else if (is_jalr)
            legal = (f3 == 3'b000);
        else if (is_br)
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
        else if (is_lw || is_sw)
            legal = (f3 == 3'b010);
        else if (is_opi)
            legal = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
        else if (is_opr)
            legal = ((f7 == 7'b0000000) &&
                     ((f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010))) ||
                    ((f7 == 7'b0100000) && (f3 == 3'b000));
    end

    // A/B/imm are registered in DECODE, so EXEC logic never sees the register file directly.
    assign op_b    = is_opr ? b_q : imm_q;
    assign ls_addr = a_q + imm_q;

    always_comb begin
        case (f3)
            3'b111:  alu_res = a_q & op_b;
            3'b110:  alu_res = a_q | op_b;
            3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(op_b)};
            default: alu_res = (is_opr && f7[5]) ? (a_q - b_q) : (a_q + op_b);
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  taken = (a_q == b_q);
            3'b001:  taken = (a_q != b_q);
            3'b100:  taken = ($signed(a_q) < $signed(b_q));
            default: taken = ($signed(a_q) >= $signed(b_q));
        endcase
    end

    assign timeout = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        result_d = result_q;
        cause_d  = cause_q;
        wait_d   = wait_q;
        rf_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    wait_d  = '0;
                    cause_d = 2'd3;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_DECODE: begin
                a_d = (rs1 == 5'd0) ? '0 : rf[rs1];
                b_d = (rs2 == 5'd0) ? '0 : rf[rs2];
                if (is_sw)
                    imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
                else if (is_br)
                    imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
                else if (is_lui || is_auipc)
                    imm_d = {ir_q[31:12], 12'b0};
                else if (is_jal)
                    imm_d = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
                else
                    imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    cause_d = 2'd1;
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    pc_d    = taken ? (pc_q + imm_q) : (pc_q + 32'd4);
                    state_d = S_FETCH;
                end else if (is_jal || is_jalr) begin
                    alu_d   = pc_q + 32'd4;
                    pc_d    = is_jal ? (pc_q + imm_q) : (ls_addr & ~32'd1);
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    if (ls_addr[1:0] != 2'b00) begin
                        cause_d = 2'd2;
                        state_d = S_HALT;
                    end else begin
                        alu_d   = ls_addr;
                        state_d = S_MEM;
                    end
                end else begin
                    if (is_lui)
                        alu_d = imm_q;
                    else if (is_auipc)
                        alu_d = pc_q + imm_q;
                    else
                        alu_d = alu_res;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    wait_d = '0;
                    if (is_sw) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FETCH;
                    end else begin
                        alu_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    wait_d  = '0;
                    cause_d = 2'd3;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            S_WB: begin
                rf_we    = (rd != 5'd0);
                result_d = alu_q;
                if (!(is_jal || is_jalr))
                    pc_d = pc_q + 32'd4;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            result_q <= '0;
            cause_q  <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            alu_q    <= alu_d;
            result_q <= result_d;
            cause_q  <= cause_d;
            wait_q   <= wait_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && !reset)
            rf[rd] <= alu_q;
    end

    assign mem_req    = !reset && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign mem_we     = (state_q == S_MEM) && is_sw;
    assign mem_addr   = (state_q == S_MEM) ? alu_q : {pc_q[31:2], 2'b00};
    assign mem_wdata  = b_q;
    assign retire     = !reset && ((state_q == S_WB) ||
                                   ((state_q == S_EXEC) && is_br) ||
                                   ((state_q == S_MEM) && is_sw && mem_ready));
    assign halted     = (state_q == S_HALT);
    assign halt_cause = cause_q;
    assign PC         = pc_q;
    assign Result     = result_q;

endmodule

// File: tb/tb_riscv_mc_cpu.sv
// Scoreboard bench for riscv_mc_cpu: programs are loaded into a behavioural
// memory with configurable wait cycles; expected retire cycles/results are queued up front.
module tb_riscv_mc_cpu;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [31:0] FILL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, PC, Result;
    logic [1:0]  halt_cause;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        bit          chk;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] mem [256];
    int          wait_cfg = 0;
    int          wcnt = 0;
    int          cyc = 0;
    bit          pend = 0;
    logic [31:0] pend_val;
    int          n_checks = 0;
    int          n_fail = 0;

    riscv_mc_cpu #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .PC(PC), .Result(Result), .retire(retire), .halted(halted), .halt_cause(halt_cause)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] u_t(input int imm, input int rd, input logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    // Memory responder: decides ready mid-cycle so the DUT sees it before the next edge.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req === 1'b1 && !reset) begin
                if (wcnt >= wait_cfg) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mem_we)
                        mem[mem_addr[9:2]] = mem_wdata;
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Scoreboard: each retire pops one expectation; Result is registered so it is checked a cycle later.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                cyc  = 0;
                pend = 0;
            end else begin
                cyc++;
                if (pend) begin
                    n_checks++;
                    if (Result !== pend_val) begin
                        n_fail++;
                        $display("FAIL result cyc=%0d got %h expected %h", cyc, Result, pend_val);
                    end
                    pend = 0;
                end
                if (retire === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL retire_unexpected cyc=%0d got retire=1 expected 0", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc) begin
                            n_fail++;
                            $display("FAIL retire_cycle got %0d expected %0d", cyc, e.cyc);
                        end
                        if (e.chk) begin
                            pend     = 1;
                            pend_val = e.res;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic void push(input int c, input logic [31:0] r, input bit chk);
        exp_t x;
        x.cyc = c;
        x.res = r;
        x.chk = chk;
        exp_q.push_back(x);
    endfunction

    task automatic begin_test(input int wc);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        wait_cfg = wc;
        for (int i = 0; i < 256; i++) mem[i] = FILL;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        #3;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(negedge clk);
            #3;
        end
    endtask

    task automatic check_sb_empty(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s sb_empty got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_halt(input string name, input logic [1:0] cause, input logic [31:0] pc);
        n_checks++;
        if (halted !== 1'b1 || halt_cause !== cause || PC !== pc) begin
            n_fail++;
            $display("FAIL %s halt got halted=%b cause=%0d pc=%h expected 1/%0d/%h",
                     name, halted, halt_cause, PC, cause, pc);
        end
    endtask

    task automatic test_reset();
        begin_test(0);
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b0 || halt_cause !== 2'd0 ||
            PC !== 32'h0 || Result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state got req=%b ret=%b halt=%b cause=%0d pc=%h res=%h expected 0s",
                     mem_req, retire, halted, halt_cause, PC, Result);
        end
        release_reset();
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_fetch got req=%b we=%b addr=%h expected 1/0/0", mem_req, mem_we, mem_addr);
        end
        to_cycle(4);
        check_halt("reset_fill", 2'd1, 32'h0);
    endtask

    task automatic test_alu();
        int reqs = 0;
        begin_test(0);
        mem[0] = i_t(5, 0, 0, 1, OPI);
        mem[1] = i_t(-7, 1, 0, 2, OPI);
        mem[2] = r_t(0, 2, 1, 0, 3);
        mem[3] = r_t(32, 1, 2, 0, 6);
        mem[4] = r_t(0, 1, 2, 2, 5);
        mem[5] = i_t(-1, 1, 2, 7, OPI);
        mem[6] = u_t(20'h12345, 8, LU);
        push(4, 32'd5, 1);
        push(8, 32'hFFFF_FFFE, 1);
        push(12, 32'd3, 1);
        push(16, 32'hFFFF_FFF9, 1);
        push(20, 32'd1, 1);
        push(24, 32'd0, 1);
        push(28, 32'h1234_5000, 1);
        release_reset();
        to_cycle(31);
        check_halt("illegal", 2'd1, 32'h1C);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            if (mem_req === 1'b1) reqs++;
        end
        n_checks++;
        if (reqs != 0) begin
            n_fail++;
            $display("FAIL halt_no_req got %0d requests expected 0", reqs);
        end
        check_sb_empty("alu");
    endtask

    task automatic test_mem_wait();
        begin_test(3);
        mem[0]    = i_t(5, 0, 0, 1, OPI);
        mem[1]    = j_t(32'h3C, 0);
        mem[16]   = s_t(8, 1, 0);
        mem[17]   = i_t(8, 0, 2, 4, LD);
        push(7, 32'd5, 1);
        push(14, 32'd8, 1);
        push(24, 32'd0, 0);
        push(35, 32'd5, 1);
        release_reset();
        to_cycle(22);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'd5) begin
            n_fail++;
            $display("FAIL store_hold got req=%b we=%b addr=%h wdata=%h expected 1/1/8/5",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        to_cycle(42);
        n_checks++;
        if (mem[2] !== 32'd5) begin
            n_fail++;
            $display("FAIL store_data got %h expected 5", mem[2]);
        end
        check_halt("mem_wait", 2'd1, 32'h48);
        check_sb_empty("mem_wait");
    endtask

    task automatic test_branch();
        begin_test(0);
        mem[0]  = j_t(32'h10, 0);
        mem[4]  = b_t(-4, 0, 0, 0);
        mem[3]  = j_t(32'h0C, 0);
        mem[6]  = b_t(8, 0, 0, 1);
        mem[7]  = i_t(-3, 0, 0, 11, OPI);
        mem[8]  = b_t(8, 0, 11, 4);
        mem[10] = b_t(8, 11, 0, 5);
        push(4, 32'h4, 1);
        push(7, 32'h0, 0);
        push(11, 32'h10, 1);
        push(14, 32'h0, 0);
        push(18, 32'hFFFF_FFFD, 1);
        push(21, 32'h0, 0);
        push(24, 32'h0, 0);
        release_reset();
        to_cycle(8);
        n_checks++;
        if (PC !== 32'h0C) begin
            n_fail++;
            $display("FAIL beq_taken got pc=%h expected 0000000c", PC);
        end
        to_cycle(15);
        n_checks++;
        if (PC !== 32'h1C) begin
            n_fail++;
            $display("FAIL bne_not_taken got pc=%h expected 0000001c", PC);
        end
        to_cycle(27);
        check_halt("branch", 2'd1, 32'h30);
        check_sb_empty("branch");
    endtask

    task automatic test_jalr();
        begin_test(0);
        mem[0] = i_t(32'h100, 0, 0, 2, OPI);
        mem[1] = j_t(32'h1C, 0);
        mem[8] = i_t(3, 2, 0, 1, JR);
        push(4, 32'h100, 1);
        push(8, 32'h8, 1);
        push(12, 32'h24, 1);
        release_reset();
        to_cycle(12);
        n_checks++;
        if (PC !== 32'h102) begin
            n_fail++;
            $display("FAIL jalr_pc got %h expected 00000102", PC);
        end
        to_cycle(13);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL jalr_fetch got req=%b addr=%h expected 1/00000100", mem_req, mem_addr);
        end
        to_cycle(15);
        check_halt("jalr", 2'd1, 32'h102);
        check_sb_empty("jalr");
    endtask

    task automatic test_misaligned();
        int reqs = 0;
        begin_test(0);
        mem[0] = i_t(6, 0, 0, 3, OPI);
        mem[1] = i_t(0, 3, 2, 5, LD);
        push(4, 32'd6, 1);
        release_reset();
        to_cycle(6);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            if (mem_req === 1'b1) reqs++;
        end
        n_checks++;
        if (reqs != 0) begin
            n_fail++;
            $display("FAIL misaligned_no_access got %0d requests expected 0", reqs);
        end
        check_halt("misaligned", 2'd2, 32'h4);
        check_sb_empty("misaligned");
    endtask

    task automatic test_timeout();
        begin_test(1000);
        release_reset();
        to_cycle(15);
        n_checks++;
        if (mem_req !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_last_wait got req=%b halted=%b expected 1/0", mem_req, halted);
        end
        to_cycle(16);
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_drop_req got %b expected 0", mem_req);
        end
        check_halt("timeout", 2'd3, 32'h0);
        check_sb_empty("timeout");
    endtask

    task automatic test_reset_mid_mem();
        begin_test(0);
        mem[0] = i_t(7, 0, 0, 12, OPI);
        mem[1] = s_t(32'h80, 12, 0);
        push(4, 32'd7, 1);
        release_reset();
        to_cycle(7);
        wait_cfg = 1000;
        to_cycle(10);
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'd7) begin
            n_fail++;
            $display("FAIL mid_mem_hold got req=%b we=%b addr=%h wdata=%h expected 1/1/80/7",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        check_sb_empty("mid_mem_pre");
        @(negedge clk);
        reset = 1'b1;
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_mem got req=%b ret=%b expected 0/0", mem_req, retire);
        end
        @(negedge clk);
        #3;
        n_checks++;
        if (PC !== 32'h0 || Result !== 32'h0 || mem_req !== 1'b0 || halted !== 1'b0 ||
            mem[32] !== FILL) begin
            n_fail++;
            $display("FAIL reset_after_mem got pc=%h res=%h req=%b halt=%b mem=%h expected 0/0/0/0/%h",
                     PC, Result, mem_req, halted, mem[32], FILL);
        end
        wait_cfg = 0;
        push(4, 32'd7, 1);
        push(8, 32'd0, 0);
        release_reset();
        to_cycle(12);
        n_checks++;
        if (mem[32] !== 32'd7) begin
            n_fail++;
            $display("FAIL rerun_store got %h expected 7", mem[32]);
        end
        check_sb_empty("mid_mem");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_jalr();
        test_misaligned();
        test_timeout();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
